// File: rtl/toggle_pkg.sv
// Shared constants and edge/mode decode for the toggle_bank channel array.
package toggle_pkg;

   localparam logic [1:0] TGL_RISE  = 2'b00;
   localparam logic [1:0] TGL_FALL  = 2'b01;
   localparam logic [1:0] TGL_BOTH  = 2'b10;
   localparam logic [1:0] TGL_LEVEL = 2'b11;

   localparam int unsigned N_MIN     = 1;
   localparam int unsigned N_MAX     = 32;
   localparam int unsigned CNT_W_MIN = 1;
   localparam int unsigned CNT_W_MAX = 16;

   // Decide whether the current trigger sample is a hit for the selected mode.
   function automatic logic hit_of(input logic [1:0] mode, input logic trig, input logic prev);
      logic h;
      case (mode)
         TGL_RISE:  h = trig & ~prev;
         TGL_FALL:  h = ~trig & prev;
         TGL_BOTH:  h = trig ^ prev;
         TGL_LEVEL: h = trig;
         default:   h = 1'b0;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/toggle_bank_if.sv
// Control/strobe inputs and per-channel outputs of toggle_bank, grouped as one bus.
interface toggle_bank_if #(
   parameter int N     = 4,
   parameter int CNT_W = 8
);
   logic                 en;
   logic [1:0]           mode;
   logic [N-1:0]         trig;
   logic [N-1:0]         clr;
   logic [N-1:0]         q;
   logic [N-1:0]         evt;
   logic [N*CNT_W-1:0]   cnt;

   modport master (output en, mode, trig, clr, input q, evt, cnt);
   modport slave  (input en, mode, trig, clr, output q, evt, cnt);
endinterface

// File: rtl/toggle_cell.sv
// One toggle channel: trigger history, toggle state, event pulse and wrapping counter.
module toggle_cell
   import toggle_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             trig,
   input  logic             clr,
   output logic             q,
   output logic             evt,
   output logic [CNT_W-1:0] cnt
);

   logic             prev_q, prev_d;
   logic             q_q, q_d;
   logic             evt_q, evt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             tgl_s;

   // Next-state decode; clear overrides toggle but trigger history always advances.
   always_comb begin
      prev_d = trig;
      tgl_s  = hit_of(mode, trig, prev_q) & en & ~clr;
      q_d    = q_q;
      evt_d  = 1'b0;
      cnt_d  = cnt_q;
      if (clr) begin
         q_d   = 1'b0;
         evt_d = 1'b0;
         cnt_d = '0;
      end else if (tgl_s) begin
         q_d   = ~q_q;
         evt_d = 1'b1;
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         q_d   = q_q;
         evt_d = 1'b0;
         cnt_d = cnt_q;
      end
   end

   // State registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q <= 1'b0;
         q_q    <= 1'b0;
         evt_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         prev_q <= prev_d;
         q_q    <= q_d;
         evt_q  <= evt_d;
         cnt_q  <= cnt_d;
      end
   end

   assign q   = q_q;
   assign evt = evt_q;
   assign cnt = cnt_q;

endmodule

// File: rtl/toggle_bank.sv
// N independent toggle channels sharing enable and edge mode; counters packed channel-major.
module toggle_bank
   import toggle_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   toggle_bank_if.slave  bus
);

   logic [N-1:0]       q_s;
   logic [N-1:0]       evt_s;
   logic [N*CNT_W-1:0] cnt_s;

   for (genvar i = 0; i < N; i++) begin : g_cell
      toggle_cell #(.CNT_W(CNT_W)) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .en    (bus.en),
         .mode  (bus.mode),
         .trig  (bus.trig[i]),
         .clr   (bus.clr[i]),
         .q     (q_s[i]),
         .evt   (evt_s[i]),
         .cnt   (cnt_s[i*CNT_W +: CNT_W])
      );
   end

   assign bus.q   = q_s;
   assign bus.evt = evt_s;
   assign bus.cnt = cnt_s;

endmodule

// File: tb/tb_toggle_bank.sv
// Bench for toggle_bank: directed vector table, async-reset sequence, randomized run vs reference model.
module tb_toggle_bank;
   import toggle_pkg::*;

   localparam int N  = 4;
   localparam int CW = 3;
   localparam int NW = N * CW;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   toggle_bank_if #(.N(N), .CNT_W(CW)) bus ();
   toggle_bank #(.N(N), .CNT_W(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int errors = 0;
   int checks = 0;

   int m_q[N], m_evt[N], m_cnt[N], m_prev[N];

   typedef struct {
      logic          en;
      logic [1:0]    mode;
      logic [N-1:0]  trig;
      logic [N-1:0]  clr;
      logic [N-1:0]  q;
      logic [N-1:0]  evt;
      logic [NW-1:0] cnt;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < N; i++) begin
         m_q[i] = 0; m_evt[i] = 0; m_cnt[i] = 0; m_prev[i] = 0;
      end
   endfunction

   // Applies one clock edge's worth of the channel rules to the model.
   function automatic void model_edge();
      for (int i = 0; i < N; i++) begin
         int t;
         bit rise, fall, hit;
         t    = int'(bus.trig[i]);
         rise = (t == 1) && (m_prev[i] == 0);
         fall = (t == 0) && (m_prev[i] == 1);
         if (bus.mode == TGL_RISE)      hit = rise;
         else if (bus.mode == TGL_FALL) hit = fall;
         else if (bus.mode == TGL_BOTH) hit = rise || fall;
         else                           hit = (t == 1);
         if (bus.clr[i]) begin
            m_q[i] = 0; m_cnt[i] = 0; m_evt[i] = 0;
         end else if (hit && bus.en) begin
            m_q[i]   = 1 - m_q[i];
            m_cnt[i] = (m_cnt[i] + 1) % (1 << CW);
            m_evt[i] = 1;
         end else begin
            m_evt[i] = 0;
         end
         m_prev[i] = t;
      end
   endfunction

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      logic [N-1:0]  eq, ee;
      logic [NW-1:0] ec;
      for (int i = 0; i < N; i++) begin
         eq[i] = m_q[i][0];
         ee[i] = m_evt[i][0];
         ec[i*CW +: CW] = CW'(m_cnt[i]);
      end
      chk({tag, ".q"},   NW'(bus.q),   NW'(eq));
      chk({tag, ".evt"}, NW'(bus.evt), NW'(ee));
      chk({tag, ".cnt"}, bus.cnt,      ec);
   endtask

   function automatic void add(input logic en, input logic [1:0] mode, input logic [N-1:0] trig,
                               input logic [N-1:0] clr, input logic [N-1:0] q,
                               input logic [N-1:0] evt, input logic [NW-1:0] cnt);
      vec_t v;
      v.en = en; v.mode = mode; v.trig = trig; v.clr = clr;
      v.q = q; v.evt = evt; v.cnt = cnt;
      tbl.push_back(v);
   endfunction

   initial begin
      // Rising edge on ch0, three pulses (first one with prev=0 right after reset).
      add(1'b1, TGL_RISE, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 12'h001);
      add(1'b1, TGL_RISE, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 12'h001);
      add(1'b1, TGL_RISE, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 12'h002);
      add(1'b1, TGL_RISE, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 12'h002);
      add(1'b1, TGL_RISE, 4'b0001, 4'b0000, 4'b0001, 4'b0001, 12'h003);
      add(1'b1, TGL_RISE, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 12'h003);
      // Both edges on ch1: high two cycles then low.
      add(1'b1, TGL_BOTH, 4'b0010, 4'b0000, 4'b0011, 4'b0010, 12'h00B);
      add(1'b1, TGL_BOTH, 4'b0010, 4'b0000, 4'b0011, 4'b0000, 12'h00B);
      add(1'b1, TGL_BOTH, 4'b0000, 4'b0000, 4'b0001, 4'b0010, 12'h013);
      // Falling edge on ch1: only the 1->0 transition toggles.
      add(1'b1, TGL_FALL, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 12'h013);
      add(1'b1, TGL_FALL, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 12'h013);
      add(1'b1, TGL_FALL, 4'b0000, 4'b0000, 4'b0011, 4'b0010, 12'h01B);
      // Level mode on ch2 for nine cycles: counter wraps 7 -> 0, ends at 1.
      for (int k = 1; k <= 9; k++)
         add(1'b1, TGL_LEVEL, 4'b0100, 4'b0000, 4'b0011 | (4'(k % 2) << 2), 4'b0100,
             12'h01B | (12'(k % 8) << 6));
      add(1'b1, TGL_LEVEL, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 12'h05B);
      // Rise on ch3 while disabled is consumed.
      add(1'b0, TGL_RISE, 4'b1000, 4'b0000, 4'b0111, 4'b0000, 12'h05B);
      add(1'b1, TGL_RISE, 4'b1000, 4'b0000, 4'b0111, 4'b0000, 12'h05B);
      add(1'b1, TGL_RISE, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 12'h05B);
      // Bring ch0 to q=1, cnt=5, then clear coincident with a rise.
      add(1'b1, TGL_RISE, 4'b0001, 4'b0000, 4'b0110, 4'b0001, 12'h05C);
      add(1'b1, TGL_RISE, 4'b0000, 4'b0000, 4'b0110, 4'b0000, 12'h05C);
      add(1'b1, TGL_RISE, 4'b0001, 4'b0000, 4'b0111, 4'b0001, 12'h05D);
      add(1'b1, TGL_RISE, 4'b0000, 4'b0000, 4'b0111, 4'b0000, 12'h05D);
      add(1'b1, TGL_RISE, 4'b0001, 4'b0001, 4'b0110, 4'b0000, 12'h058);

      rst_n = 1'b0;
      bus.en = 1'b0; bus.mode = TGL_RISE; bus.trig = '0; bus.clr = '0;
      model_reset();
      #12;
      chk("reset.q",   NW'(bus.q),   '0);
      chk("reset.evt", NW'(bus.evt), '0);
      chk("reset.cnt", bus.cnt,      '0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         bus.en = tbl[i].en; bus.mode = tbl[i].mode;
         bus.trig = tbl[i].trig; bus.clr = tbl[i].clr;
         step();
         chk($sformatf("vec%0d.q", i),   NW'(bus.q),   NW'(tbl[i].q));
         chk($sformatf("vec%0d.evt", i), NW'(bus.evt), NW'(tbl[i].evt));
         chk($sformatf("vec%0d.cnt", i), bus.cnt,      tbl[i].cnt);
      end

      // Asynchronous reset between edges while evt[0] is high.
      bus.en = 1'b1; bus.mode = TGL_RISE; bus.clr = '0; bus.trig = 4'b0000;
      step();
      bus.trig = 4'b0001;
      step();
      chk("pre_rst.evt", NW'(bus.evt), NW'(4'b0001));
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst.q",   NW'(bus.q),   '0);
      chk("async_rst.evt", NW'(bus.evt), '0);
      chk("async_rst.cnt", bus.cnt,      '0);
      bus.trig = 4'b0000;
      #2;
      rst_n = 1'b1;
      step();
      chk("post_rst.evt", NW'(bus.evt), '0);
      chk("post_rst.q",   NW'(bus.q),   '0);
      step();
      chk("post_rst2.cnt", bus.cnt, '0);

      // Randomized run against the reference model, with one mid-run async reset.
      for (int c = 0; c < 400; c++) begin
         bus.en   = ($urandom_range(0, 7) != 0);
         bus.mode = 2'($urandom_range(0, 3));
         bus.trig = N'($urandom);
         for (int i = 0; i < N; i++) bus.clr[i] = ($urandom_range(0, 15) == 0);
         step();
         check_model($sformatf("rnd%0d", c));
         if (c == 200) begin
            #2;
            rst_n = 1'b0;
            model_reset();
            #1;
            check_model("rnd_rst");
            #1;
            rst_n = 1'b1;
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/toggle_bank.md
# toggle_bank

Parametrised, multi-channel successor to the single-bit toggle flip-flop. Each of `N` channels keeps a state bit that flips on a selectable edge of its trigger input. Each channel also provides a registered event pulse, a per-channel toggle counter and a synchronous clear. The block sits between raw control/strobe inputs and downstream logic that needs divide-by-two or on/off state tracking per line.

## Interface

Parameters:
- `N`, default 4: number of independent channels, 1..32.
- `CNT_W`, default 8: width of each channel's toggle counter, 1..16.

Ports:
- `clk`, input, 1: single clock; all registers update on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: global toggle enable.
- `mode`, input, 2: edge select, shared by all channels.
  - 00: rising edge.
  - 01: falling edge.
  - 10: both edges.
  - 11: level (toggle every cycle trigger is 1).
- `trig`, input, N: per-channel trigger inputs, synchronous to `clk`.
- `clr`, input, N: per-channel synchronous clear.
- `q`, output, N: per-channel toggle state (register output).
- `evt`, output, N: one-cycle registered pulse, asserted in the same cycle a channel's `q` changes.
- `cnt`, output, N*CNT_W: flattened counters; channel i occupies bits [i*CNT_W +: CNT_W].

## Operation

- Per channel, a `prev` register holds the trigger value sampled at the previous clock edge.
- Edge detection is combinational from `trig[i]` and `prev[i]`:
  - rise = `trig & ~prev`
  - fall = `~trig & prev`
- Hit condition per mode:
  - 00: rise.
  - 01: fall.
  - 10: rise | fall.
  - 11: `trig`.
- Toggle condition: hit & `en` & ~`clr[i]`. When it holds:
  - `q[i]` <= ~`q[i]`.
  - `evt[i]` <= 1.
  - `cnt[i]` <= `cnt[i]` + 1, wrapping modulo 2^CNT_W (all-ones -> 0).
- When the toggle condition does not hold, `evt[i]` <= 0.
- `clr[i]` has priority over any toggle:
  - It forces `q[i]` <= 0, `cnt[i]` <= 0 and `evt[i]` <= 0.
  - `prev[i]` still samples `trig[i]` normally.
- `prev` always samples `trig`, regardless of `en` or `clr`. An edge that occurs while disabled is therefore consumed; it does not fire when `en` returns.
- A `mode` change takes effect on the next edge evaluation, with no state flush.
- Channels are fully independent apart from the shared `en` and `mode`.

## Timing

- Reset (`rst_n` = 0, asynchronous):
  - `q`, `evt`, `cnt` and `prev` all go to 0 immediately.
  - Reset may be asserted mid-operation. All state is lost and no pulse is emitted on release.
- After reset release, `prev` = 0. In modes 00 and 10, a `trig` already at 1 on the first active edge counts as a rising edge.
- Latency: `trig` first seen at new value on edge k -> `q`, `evt` and `cnt` update after edge k, i.e. visible in cycle k+1. This is one register stage, with no combinational input-to-output path.
- Level mode with `trig` held high: `q` alternates every cycle, `evt` stays at 1 continuously, and `cnt` increments every cycle.
- Both-edge mode with `trig` toggling every cycle: a hit occurs every cycle.
- When `clr[i]` and a toggle condition coincide: the result is `q` = 0, `cnt` = 0, `evt` = 0.
- Deasserting `en` blocks toggles from that same edge onward.

## Structure

- Package `toggle_pkg` holds:
  - Mode localparams `TGL_RISE` = 2'b00, `TGL_FALL` = 2'b01, `TGL_BOTH` = 2'b10, `TGL_LEVEL` = 2'b11.
  - Limits for `N` and `CNT_W`.
- Sub-module `toggle_cell`: one channel, containing `prev`, `q`, `evt` and the `CNT_W` counter. Its ports are `clk`, `rst_n`, `en`, `mode`, `trig`, `clr`, `q`, `evt` and `cnt`.
- `toggle_bank` instantiates `N` cells in a generate loop and packs `cnt`.
- Edge and mode decode may use the existing `eq`, `and_comp`, `not_comp` and `mux21_comp` primitives, or equivalent behavioural code.

## Test plan

- **Reset and rising edge.** Reset, then N = 4, `mode` = 00, `en` = 1, `trig[0]` pulses 0->1->0 three times. Required: `q[0]` sequence 1, 0, 1; three single-cycle `evt[0]` pulses; `cnt[0]` = 3; other channels remain 0.
- **Both edges and falling edge.** `mode` = 10, `trig[1]` = 1 for 2 cycles then 0. Required: two toggles, `q[1]` = 0, `cnt[1]` = 2. Repeat with `mode` = 01: exactly one toggle, on the 1->0 transition.
- **Level mode and wrap.** `mode` = 11, CNT_W = 3, `trig[2]` held at 1 for 9 cycles. Required: `q[2]` alternates each cycle; `evt[2]` stays at 1; `cnt[2]` wraps from 7 to 0 and ends at 1; final `q[2]` = 1.
- **Disabled edge consumed.** `en` = 0 while `trig[3]` rises, then `en` = 1 with `trig[3]` held high. Required: no toggle, `q[3]` = 0, `cnt[3]` = 0.
- **Clear priority.** `clr[0]` = 1 coincident with a rising edge on `trig[0]`, with `q[0]` = 1 and `cnt[0]` = 5 beforehand. Required: next cycle `q[0]` = 0, `cnt[0]` = 0, `evt[0]` = 0.
- **Asynchronous reset mid-pulse.** Assert `rst_n` = 0 between clock edges while `evt` = 1. Required: `q`, `evt` and `cnt` go to 0 immediately without a clock edge; no `evt` on release with `trig` = 0.
